// File: rtl/pll_dig_loop.sv
// rtl/pll_dig_loop.sv - digital PLL loop: binary-search frequency acquisition, then PI phase tracking.
module pll_dig_loop #(
    parameter int FBDIV_W        = 8,
    parameter int CODE_W         = 12,
    parameter int ERR_W          = 8,
    parameter int CODE_INIT      = 2048,
    parameter int KP_SHIFT       = 2,
    parameter int KI_SHIFT       = 4,
    parameter int REACQ_STEP     = 4,
    parameter int LOCK_TOL       = 2,
    parameter int LOCK_COUNT_MAX = 10
) (
    input  logic                    rclk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hold,
    input  logic [FBDIV_W-1:0]      fbdiv,
    input  logic [FBDIV_W+1:0]      fb_count,
    input  logic                    fb_count_vld,
    input  logic signed [ERR_W-1:0] tdc_err,
    input  logic                    tdc_vld,
    output logic [CODE_W-1:0]       dco_code,
    output logic                    freq_lock,
    output logic                    lock,
    output logic [1:0]              state
);

    localparam int DW = FBDIV_W + 3;
    localparam int IW = CODE_W + KI_SHIFT;
    localparam int SW = IW + 2;
    localparam int CW = $clog2(LOCK_COUNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FACQ  = 2'd1,
        S_TRACK = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic [CODE_W-1:0] step, step_n;
    logic [IW-1:0]     integ, integ_n;
    logic [CW-1:0]     lock_cnt, lock_cnt_n;
    logic [CODE_W-1:0] dco_n;
    logic              freq_lock_n, lock_n;
    logic              prev_neg, prev_neg_n;
    logic              have_prev, have_prev_n;
    logic              zero_seen, zero_seen_n;

    // Two extra bits: bit CODE_W+1 flags underflow, bit CODE_W flags overflow.
    function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W+1:0] v);
        if (v[CODE_W+1])
            return '0;
        else if (v[CODE_W])
            return '1;
        else
            return v[CODE_W-1:0];
    endfunction

    logic [DW-1:0]        target_ext, fb_ext;
    logic signed [DW-1:0] diff;
    logic                 diff_zero, diff_neg, slip;

    assign target_ext = (fbdiv == '0) ? DW'(1) : DW'(fbdiv);
    assign fb_ext     = DW'(fb_count);
    assign diff       = target_ext - fb_ext;
    assign diff_zero  = (diff == '0);
    assign diff_neg   = diff[DW-1];
    assign slip       = !(diff_zero || (diff == DW'(1)) || (diff == '1));

    logic [CODE_W-1:0] step_half, step_eff;
    logic [CODE_W+1:0] facq_sum;
    logic [CODE_W-1:0] facq_code;

    // The search step shrinks only when the frequency error changes sign.
    assign step_half = ((step >> 1) == '0) ? CODE_W'(1) : (step >> 1);
    assign step_eff  = (have_prev && (prev_neg != diff_neg)) ? step_half : step;
    assign facq_sum  = diff_neg ? ({2'b00, dco_code} - {2'b00, step_eff})
                                : ({2'b00, dco_code} + {2'b00, step_eff});
    assign facq_code = sat_code(facq_sum);

    logic [SW-1:0]           err_ext, int_sum;
    logic [IW-1:0]           integ_next;
    logic signed [ERR_W-1:0] p_err;
    logic [CODE_W+1:0]       p_ext, track_sum;
    logic [CODE_W-1:0]       track_code;
    logic [ERR_W-1:0]        err_abs;
    logic                    err_small;

    assign err_ext    = {{(SW-ERR_W){tdc_err[ERR_W-1]}}, tdc_err};
    assign int_sum    = {2'b00, integ} + err_ext;
    assign integ_next = int_sum[SW-1] ? '0 : (int_sum[SW-2] ? '1 : int_sum[IW-1:0]);
    assign p_err      = tdc_err >>> KP_SHIFT;
    assign p_ext      = {{(CODE_W+2-ERR_W){p_err[ERR_W-1]}}, p_err};
    assign track_sum  = {2'b00, integ_next[IW-1:KI_SHIFT]} + p_ext;
    assign track_code = sat_code(track_sum);
    assign err_abs    = tdc_err[ERR_W-1] ? (~tdc_err + ERR_W'(1)) : tdc_err;
    assign err_small  = (err_abs <= ERR_W'(LOCK_TOL));

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n)
            cur_state <= S_IDLE;
        else
            cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (!en) begin
            nxt_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE:  nxt_state = S_FACQ;
                S_FACQ:  if (fb_count_vld && diff_zero && zero_seen) nxt_state = S_TRACK;
                S_TRACK: begin
                    if (hold)
                        nxt_state = S_HOLD;
                    else if (fb_count_vld && slip)
                        nxt_state = S_FACQ;
                end
                S_HOLD:  if (!hold) nxt_state = S_TRACK;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        dco_n       = dco_code;
        step_n      = step;
        integ_n     = integ;
        lock_cnt_n  = lock_cnt;
        freq_lock_n = freq_lock;
        lock_n      = lock;
        prev_neg_n  = prev_neg;
        have_prev_n = have_prev;
        zero_seen_n = zero_seen;
        if (!en) begin
            dco_n       = CODE_W'(CODE_INIT);
            step_n      = '0;
            integ_n     = '0;
            lock_cnt_n  = '0;
            freq_lock_n = 1'b0;
            lock_n      = 1'b0;
            prev_neg_n  = 1'b0;
            have_prev_n = 1'b0;
            zero_seen_n = 1'b0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    dco_n       = CODE_W'(CODE_INIT);
                    step_n      = CODE_W'(1) << (CODE_W - 2);
                    lock_cnt_n  = '0;
                    freq_lock_n = 1'b0;
                    lock_n      = 1'b0;
                    have_prev_n = 1'b0;
                    zero_seen_n = 1'b0;
                end
                S_FACQ: begin
                    if (fb_count_vld) begin
                        if (diff_zero) begin
                            zero_seen_n = 1'b1;
                            if (zero_seen) begin
                                freq_lock_n = 1'b1;
                                integ_n     = IW'(dco_code) << KI_SHIFT;
                            end
                        end else begin
                            zero_seen_n = 1'b0;
                            step_n      = step_eff;
                            dco_n       = facq_code;
                            prev_neg_n  = diff_neg;
                            have_prev_n = 1'b1;
                        end
                    end
                end
                S_TRACK: begin
                    if (hold) begin
                        dco_n = dco_code;
                    end else if (fb_count_vld && slip) begin
                        // Cycle slip: re-acquire from the current code with a small step.
                        step_n      = CODE_W'(REACQ_STEP);
                        freq_lock_n = 1'b0;
                        lock_n      = 1'b0;
                        lock_cnt_n  = '0;
                        have_prev_n = 1'b0;
                        zero_seen_n = 1'b0;
                    end else if (tdc_vld) begin
                        integ_n = integ_next;
                        dco_n   = track_code;
                        if (!err_small)
                            lock_cnt_n = '0;
                        else if (lock_cnt != CW'(LOCK_COUNT_MAX))
                            lock_cnt_n = lock_cnt + CW'(1);
                        lock_n = (lock_cnt_n == CW'(LOCK_COUNT_MAX));
                    end
                end
                default: begin
                    dco_n = dco_code;
                end
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            dco_code  <= CODE_W'(CODE_INIT);
            step      <= '0;
            integ     <= '0;
            lock_cnt  <= '0;
            freq_lock <= 1'b0;
            lock      <= 1'b0;
            prev_neg  <= 1'b0;
            have_prev <= 1'b0;
            zero_seen <= 1'b0;
        end else begin
            dco_code  <= dco_n;
            step      <= step_n;
            integ     <= integ_n;
            lock_cnt  <= lock_cnt_n;
            freq_lock <= freq_lock_n;
            lock      <= lock_n;
            prev_neg  <= prev_neg_n;
            have_prev <= have_prev_n;
            zero_seen <= zero_seen_n;
        end
    end

    assign state = cur_state;

endmodule
